fcore_issue_scheduler: RTL
==========================

// Module: fcore_issue_scheduler
// PURPOSE
//  Scoreboarded issue controller between fCore decode and the FP/logic datapath.
//  Accepts decoded instructions over valid/ready and issues in order.
//  Stalls on RAW/WAW register hazards and on collisions on the single writeback port.
//  Handles STOP by draining in-flight results, then signals program completion.
// PARAMETERS
//  REG_ADDR_WIDTH  6  register file address width (2**REG_ADDR_WIDTH registers)
//  LAT_ADDSUB      5  ADD/SUB result latency, cycles from accept to writeback
//  LAT_MUL         6  MUL latency
//  LAT_CONV        4  ITF/FTI latency
//  LAT_REC         9  REC latency
//  LAT_LOGIC       1  LDC/LDR/LAND/LOR/LNOT/SATP/SATN/POPCNT/ABS latency
//  MAX_LAT         9  writeback reservation depth; must be >= every LAT_* above
// PORTS
//  clock          in   1    system clock
//  reset          in   1    synchronous reset, active low
//  start          in   1    one-cycle pulse: IDLE/DONE -> RUN
//  done           out  1    high in DONE
//  busy           out  1    high in RUN or DRAIN
//  illegal_op     out  1    sticky: opcode 21..31 accepted; cleared by start/reset
//  instr_valid    in   1    decoded instruction valid
//  instr_ready    out  1    scheduler can accept (combinational)
//  instr_opcode   in   5    opcode, fcore ISA encoding 0..20
//  instr_rs1/rs2  in   REG_ADDR_WIDTH  source registers
//  instr_rd       in   REG_ADDR_WIDTH  destination register
//  issue_valid    out  1    registered, one pulse per accepted non-NOP instruction
//  issue_opcode   out  5    registered copy of accepted opcode
//  issue_rs1/rs2/rd out REG_ADDR_WIDTH registered copies
//  wb_valid       out  1    scheduled writeback retires this cycle
//  wb_rd          out  REG_ADDR_WIDTH  register being written back
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; scoreboard and reservation shift register cleared.
//  FSM: IDLE -start-> RUN; RUN -STOP accepted-> DONE; RUN -STOP pending, in-flight>0-> DRAIN;
//   DRAIN -reservation empty-> DONE; DONE -start-> RUN. start ignored in RUN/DRAIN.
//  Classes: writers = ADD SUB MUL ITF FTI REC + LATENCY_LOGIC group; readers only =
//   BGT BLE BEQ BNE (rs1, rs2, no rd); NOP/STOP read and write nothing.
//   LDC/LDR/ITF/FTI/LNOT/REC/POPCNT/ABS read rs1 only; others read rs1 and rs2.
//  instr_ready = (state==RUN) & !RAW & !WAW & !slot_conflict & !(STOP & inflight).
//   RAW: a read source busy. WAW: writer rd busy. slot_conflict: writer with
//   reservation bit [L-1] already set. STOP with in-flight results -> DRAIN, no accept.
//  Accept at cycle T (valid&ready), writer latency L: busy[rd] and rsv[L-1] set at end of T;
//   issue_* valid in T+1; wb_valid/wb_rd asserted in cycle T+L; busy[rd] cleared at end of T+L.
//   Dependent reader earliest accept T+L+1 (no bypass).
//  Reservation: MAX_LAT-bit shift register plus rd tag per slot, shifts down every cycle;
//   slot 0 drives wb_valid/wb_rd. Shift and new set in same cycle: new entry lands at L-1 after shift.
//  Same-cycle retire of rd X and accept of new writer to X: not allowed (WAW stalls one cycle).
//  Illegal opcode 21..31: accepted as NOP, illegal_op set, no issue pulse.
//  NOP: accepted, no issue pulse, no scoreboard effect.
//  done/busy registered, change the cycle after the FSM transition.
//  Reset mid-operation discards all in-flight reservations; no wb_valid after reset.
// CONFIGURATION
//  FCORE_SCHED_STATS_EN defined: adds outputs stall_cycles[31:0] (cycles in RUN/DRAIN with
//   instr_valid & !instr_ready) and issued_count[31:0] (issue_valid pulses); both
//   cleared by reset and start, saturate at 2**32-1.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  start; ADD r1,r2,r3 then MUL r4,r1,r5 back-to-back -> MUL ready low 5 cycles,
//   accepted at T+6; wb_valid r1 at T+5, r4 at T+12.
//  MUL r1 at T, ADD r2 at T+1 (both retire at T+6) -> ADD stalls 1 cycle, wb r2 at T+7.
//  REC r1, then STOP next cycle -> busy=1, state DRAIN 8 cycles, done=1 after wb r1, ready=0.
//  Opcode 25 accepted -> illegal_op=1, issue_valid stays 0; start clears illegal_op.
//  reset low 1 cycle with 3 results in flight -> no wb_valid after, done=busy=0, IDLE.
//  FCORE_SCHED_STATS_EN: scenario 1 -> stall_cycles=5, issued_count=2.

Source files
------------

// File: rtl/fcore_issue_scheduler.sv
// fcore_issue_scheduler
//   Scoreboarded in-order issue controller between fCore decode and the FP/logic datapath.
//   Accepts one decoded instruction per cycle over valid/ready. It stalls on RAW and WAW register
//   hazards and on collisions on the single writeback port. STOP drains in-flight results and then
//   signals completion.
//
//   Ports
//     clock, reset        system clock, synchronous active-low reset
//     start               pulse, IDLE/DONE -> RUN (ignored in RUN/DRAIN)
//     done, busy          registered status (DONE / RUN or DRAIN)
//     illegal_op          sticky flag for opcodes 21..31, cleared by start/reset
//     instr_*             decoded instruction handshake (instr_ready is combinational)
//     issue_*             registered copy of each accepted non-NOP instruction
//     wb_valid, wb_rd     scheduled writeback retiring this cycle
//     stall_cycles, issued_count   only when FCORE_SCHED_STATS_EN is defined
//
//   Optional feature macro: FCORE_SCHED_STATS_EN (stall/issue counters).
//
//   Opcode map: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 ITF, 5 FTI, 6 LDC, 7 LDR, 8 BGT, 9 BLE, 10 BEQ,
//   11 BNE, 12 STOP, 13 LAND, 14 LOR, 15 LNOT, 16 SATP, 17 SATN, 18 REC, 19 POPCNT, 20 ABS.
module fcore_issue_scheduler #(
  parameter int unsigned REG_ADDR_WIDTH = 6,
  parameter int unsigned LAT_ADDSUB     = 5,
  parameter int unsigned LAT_MUL        = 6,
  parameter int unsigned LAT_CONV       = 4,
  parameter int unsigned LAT_REC        = 9,
  parameter int unsigned LAT_LOGIC      = 1,
  parameter int unsigned MAX_LAT        = 9
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  output logic                      illegal_op,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [4:0]                instr_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] instr_rd,
  output logic                      issue_valid,
  output logic [4:0]                issue_opcode,
  output logic [REG_ADDR_WIDTH-1:0] issue_rs1,
  output logic [REG_ADDR_WIDTH-1:0] issue_rs2,
  output logic [REG_ADDR_WIDTH-1:0] issue_rd,
  output logic                      wb_valid,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd
`ifdef FCORE_SCHED_STATS_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [31:0]               issued_count
`endif
);

  localparam int unsigned NumRegs = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned LatW    = $clog2(MAX_LAT + 1);

  localparam logic [4:0] OpNop    = 5'd0;
  localparam logic [4:0] OpAdd    = 5'd1;
  localparam logic [4:0] OpSub    = 5'd2;
  localparam logic [4:0] OpMul    = 5'd3;
  localparam logic [4:0] OpItf    = 5'd4;
  localparam logic [4:0] OpFti    = 5'd5;
  localparam logic [4:0] OpLdc    = 5'd6;
  localparam logic [4:0] OpLdr    = 5'd7;
  localparam logic [4:0] OpBgt    = 5'd8;
  localparam logic [4:0] OpBle    = 5'd9;
  localparam logic [4:0] OpBeq    = 5'd10;
  localparam logic [4:0] OpBne    = 5'd11;
  localparam logic [4:0] OpStop   = 5'd12;
  localparam logic [4:0] OpLand   = 5'd13;
  localparam logic [4:0] OpLor    = 5'd14;
  localparam logic [4:0] OpLnot   = 5'd15;
  localparam logic [4:0] OpSatp   = 5'd16;
  localparam logic [4:0] OpSatn   = 5'd17;
  localparam logic [4:0] OpRec    = 5'd18;
  localparam logic [4:0] OpPopcnt = 5'd19;
  localparam logic [4:0] OpAbs    = 5'd20;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  // Per-register pending-write scoreboard.
  logic [NumRegs-1:0] reg_busy_q, reg_busy_d;
  // Writeback reservation shift register with destination tag per slot; slot 0 retires.
  logic [MAX_LAT-1:0]                     rsv_q, rsv_d;
  logic [MAX_LAT-1:0][REG_ADDR_WIDTH-1:0] tag_q, tag_d;

  logic                      done_q, done_d;
  logic                      run_q, run_d;
  logic                      illegal_q, illegal_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [4:0]                issue_opcode_q, issue_opcode_d;
  logic [REG_ADDR_WIDTH-1:0] issue_rs1_q, issue_rs1_d;
  logic [REG_ADDR_WIDTH-1:0] issue_rs2_q, issue_rs2_d;
  logic [REG_ADDR_WIDTH-1:0] issue_rd_q, issue_rd_d;

  // Decode
  logic            is_wr, use_rs1, use_rs2, is_stop, is_nop, is_illegal;
  logic [LatW-1:0] lat;

  always_comb begin
    is_wr      = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    is_stop    = 1'b0;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    lat        = '0;
    case (instr_opcode)
      OpAdd, OpSub: begin
        is_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; lat = LatW'(LAT_ADDSUB);
      end
      OpMul: begin
        is_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; lat = LatW'(LAT_MUL);
      end
      OpItf, OpFti: begin
        is_wr = 1'b1; use_rs1 = 1'b1; lat = LatW'(LAT_CONV);
      end
      OpRec: begin
        is_wr = 1'b1; use_rs1 = 1'b1; lat = LatW'(LAT_REC);
      end
      OpLdc, OpLdr, OpLnot, OpPopcnt, OpAbs: begin
        is_wr = 1'b1; use_rs1 = 1'b1; lat = LatW'(LAT_LOGIC);
      end
      OpLand, OpLor, OpSatp, OpSatn: begin
        is_wr = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; lat = LatW'(LAT_LOGIC);
      end
      OpBgt, OpBle, OpBeq, OpBne: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OpStop:  is_stop = 1'b1;
      OpNop:   is_nop  = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

  // Hazards and handshake
  logic [MAX_LAT-1:0] rsv_shift, lat_oh;
  logic               raw, waw, slot_conflict, inflight, accept, start_go;

  always_comb begin
    rsv_shift = rsv_q >> 1;
    for (int i = 0; i < int'(MAX_LAT); i++) begin
      lat_oh[i] = (lat == LatW'(i + 1));
    end
    raw = (use_rs1 && reg_busy_q[instr_rs1]) || (use_rs2 && reg_busy_q[instr_rs2]);
    waw = is_wr && reg_busy_q[instr_rd];
    // A new entry lands at slot L-1 after this cycle's shift, so test the shifted vector.
    slot_conflict = is_wr && |(lat_oh & rsv_shift);
    inflight      = |rsv_q;
    instr_ready   = (state_q == StRun) && !raw && !waw && !slot_conflict &&
                    !(is_stop && inflight);
    accept        = instr_valid && instr_ready;
    start_go      = start && ((state_q == StIdle) || (state_q == StDone));
  end

  // Next state
  always_comb begin
    rsv_d = rsv_shift | ((accept && is_wr) ? lat_oh : '0);
    tag_d = tag_q >> REG_ADDR_WIDTH;
    for (int i = 0; i < int'(MAX_LAT); i++) begin
      if (accept && is_wr && lat_oh[i]) tag_d[i] = instr_rd;
    end

    // WAW stalls prevent a retire and a new set on the same register in one cycle.
    reg_busy_d = reg_busy_q;
    if (rsv_q[0]) reg_busy_d[tag_q[0]] = 1'b0;
    if (accept && is_wr) reg_busy_d[instr_rd] = 1'b1;

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (accept && is_stop)                      state_d = StDone;
        else if (instr_valid && is_stop && inflight) state_d = StDrain;
      end
      StDrain: if (rsv_d == '0) state_d = StDone;
      StDone:  if (start) state_d = StRun;
    endcase

    done_d    = (state_d == StDone);
    run_d     = (state_d == StRun) || (state_d == StDrain);
    illegal_d = start_go ? 1'b0 : (illegal_q || (accept && is_illegal));

    issue_valid_d  = accept && !is_nop && !is_illegal;
    issue_opcode_d = issue_opcode_q;
    issue_rs1_d    = issue_rs1_q;
    issue_rs2_d    = issue_rs2_q;
    issue_rd_d     = issue_rd_q;
    if (issue_valid_d) begin
      issue_opcode_d = instr_opcode;
      issue_rs1_d    = instr_rs1;
      issue_rs2_d    = instr_rs2;
      issue_rd_d     = instr_rd;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= StIdle;
      reg_busy_q     <= '0;
      rsv_q          <= '0;
      tag_q          <= '0;
      done_q         <= 1'b0;
      run_q          <= 1'b0;
      illegal_q      <= 1'b0;
      issue_valid_q  <= 1'b0;
      issue_opcode_q <= '0;
      issue_rs1_q    <= '0;
      issue_rs2_q    <= '0;
      issue_rd_q     <= '0;
    end else begin
      state_q        <= state_d;
      reg_busy_q     <= reg_busy_d;
      rsv_q          <= rsv_d;
      tag_q          <= tag_d;
      done_q         <= done_d;
      run_q          <= run_d;
      illegal_q      <= illegal_d;
      issue_valid_q  <= issue_valid_d;
      issue_opcode_q <= issue_opcode_d;
      issue_rs1_q    <= issue_rs1_d;
      issue_rs2_q    <= issue_rs2_d;
      issue_rd_q     <= issue_rd_d;
    end
  end

  assign done         = done_q;
  assign busy         = run_q;
  assign illegal_op   = illegal_q;
  assign issue_valid  = issue_valid_q;
  assign issue_opcode = issue_opcode_q;
  assign issue_rs1    = issue_rs1_q;
  assign issue_rs2    = issue_rs2_q;
  assign issue_rd     = issue_rd_q;
  assign wb_valid     = rsv_q[0];
  assign wb_rd        = rsv_q[0] ? tag_q[0] : '0;

`ifdef FCORE_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d, issued_q, issued_d;

  always_comb begin
    stall_d  = stall_q;
    issued_d = issued_q;
    if (start_go) begin
      stall_d  = '0;
      issued_d = '0;
    end else begin
      if (((state_q == StRun) || (state_q == StDrain)) && instr_valid && !instr_ready &&
          (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
      if (issue_valid_q && (issued_q != '1)) issued_d = issued_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q  <= '0;
      issued_q <= '0;
    end else begin
      stall_q  <= stall_d;
      issued_q <= issued_d;
    end
  end

  assign stall_cycles = stall_q;
  assign issued_count = issued_q;
`endif

endmodule
